mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-port unified memory between the pipeline's instruction-fetch port and its data (MEM-stage) port. The arbiter gives data accesses priority, with a bounded-starvation guarantee for fetch. It sequences each access through a fixed-latency memory and returns read data with a one-cycle valid pulse. It sits between the `risc_v_cpu` IF/MEM stages and the memory model, and replaces the separate imem/dmem arrays used so far.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `MEM_LAT`, 2: cycles from memory command to `mem_rdata` valid; legal range 1..8.
- `STARVE_MAX`, 4: maximum consecutive data grants while a fetch waits; legal range 1..15.

- `clk` in 1: single clock; all state on the rising edge.
- `rst` in 1: asynchronous, active-low reset (0 = reset).
- `if_req` in 1: fetch request; held with `if_addr` until `if_gnt`.
- `if_addr` in ADDR_W: fetch byte address.
- `if_kill` in 1: discard the in-flight or same-cycle-granted fetch response (branch/flush).
- `if_gnt` out 1: fetch accepted this cycle.
- `if_rvalid` out 1: one-cycle pulse; `if_rdata` is valid.
- `if_rdata` out DATA_W: fetched word; held until the next `if_rvalid`.
- `d_req` in 1: data request; held with `d_we`, `d_addr` and `d_wdata` until `d_gnt`.
- `d_we` in 1: 1 = write, 0 = read.
- `d_addr` in ADDR_W: data byte address.
- `d_wdata` in DATA_W: write data.
- `d_gnt` out 1: data access accepted this cycle.
- `d_rvalid` out 1: one-cycle pulse for data reads only.
- `d_rdata` out DATA_W: load data; held until the next `d_rvalid`.
- `mem_en` out 1: memory command strobe.
- `mem_we` out 1: memory write enable; qualified by `mem_en`.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_rdata` in DATA_W: memory read data; valid `MEM_LAT` cycles after the read command.
- `busy` out 1: arbiter is not in IDLE.

## Operation
- **FSM states:** IDLE, RD_WAIT.
- **IDLE arbitration** (combinational in the same cycle):
  - If `d_req` and the starvation counter is below `STARVE_MAX`, or `d_req` with `!if_req`: grant data.
  - Else if `if_req`: grant fetch.
  - Else: no grant.
- **Grant cycle:**
  - Exactly one of `if_gnt`/`d_gnt` is high.
  - `mem_en`=1, and `mem_addr`/`mem_we`/`mem_wdata` are taken from the winner.
  - A fetch drives `mem_we`=0 and `mem_wdata`=0.
- **Write grant:** completes in that cycle; FSM stays in IDLE; no `d_rvalid`.
- **Read grant:**
  - Move to RD_WAIT; load a latency counter with `MEM_LAT`.
  - Latch the owner (fetch/data) and `kill_pending` = `if_kill` for a fetch grant.
- **RD_WAIT:**
  - The counter decrements each cycle.
  - On the cycle `mem_rdata` is valid (counter = 1), capture it into the owner's rdata register and return to IDLE.
- **Response:** the owner's rvalid pulses in the cycle after capture, except that a fetch with `kill_pending` set produces no `if_rvalid` and leaves `if_rdata` unchanged.
- **Kill:** `if_kill` high in any RD_WAIT cycle of a fetch sets `kill_pending`. `if_kill` has no effect on data reads or when no fetch is outstanding.
- **Starvation counter:**
  - Increments on each data grant while `if_req`=1, saturating at `STARVE_MAX`.
  - Clears on a fetch grant, and in any cycle with `if_req`=0.
- **Outputs when not granting:** `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- **`busy`:** = (state == RD_WAIT).
- **Reset:**
  - Asynchronous.
  - Every output goes to 0 and is held at 0 while `rst`=0. `if_gnt`/`d_gnt` are gated by reset even though they are combinational.
  - FSM returns to IDLE; the counters, the owner latch and `kill_pending` clear.
  - A read in flight at reset is dropped: no rvalid is issued after reset release.

## Timing
- **Read issued in cycle T:**
  - `gnt`/`mem_en` are high in T.
  - `mem_rdata` is sampled at the end of T+`MEM_LAT`.
  - rvalid is high in T+`MEM_LAT`+1.
- **Read occupancy:** the arbiter is back in IDLE in T+`MEM_LAT`+1 and may grant in that same cycle, concurrently with the rvalid pulse. The back-to-back read period is `MEM_LAT`+1 cycles.
- **Writes:** occupy one cycle; a new grant is possible in T+1.
- **Stalls:** no grant is ever issued in RD_WAIT. Requesters stall on `req && !gnt`.
- **`d_gnt`:**
  - With `MEM_LAT`=1 and no competing fetch, a read is granted at most every 2 cycles.
  - With continuous fetch competition, fetch gets at least 1 of every `STARVE_MAX`+1 grants.

## Test plan
- **Reset mid-read:** issue a fetch read of addr 0x8 with `MEM_LAT`=2, and assert `rst`=0 in T+1 → all outputs 0 immediately; after release, no `if_rvalid` and `busy`=0.
- **Single fetch:** `if_req`, `if_addr`=0x4, memory returns 0x00300113 at T+2 → `if_gnt`@T, `if_rvalid`@T+3 with `if_rdata`=0x00300113, `busy` high T+1..T+2.
- **Simultaneous requests:** `if_req`=`d_req`=1 at T with `d_we`=0 and `d_addr`=0xC → `d_gnt`@T; `if_gnt`@T+3 (`MEM_LAT`=2); `d_rvalid`@T+3.
- **Data write:** `d_we`=1, `d_addr`=0x10, `d_wdata`=0x8 → `mem_en`=`mem_we`=1, `mem_addr`=0x10 and `mem_wdata`=8 in T; a fetch is granted at T+1; no `d_rvalid`.
- **Starvation bound:** with `STARVE_MAX`=4, hold `d_req` (writes) and `if_req` high continuously → grant sequence D,D,D,D,F repeating.
- **Fetch kill:** grant a fetch read at T and pulse `if_kill` at T+1 → no `if_rvalid` at T+3, `if_rdata` keeps its old value, and the next grant still occurs at T+3.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port, fixed-latency unified memory between
//               the instruction-fetch port and the data (MEM-stage) port.
//               Data accesses win arbitration. A starvation counter makes
//               sure a waiting fetch is served after at most STARVE_MAX data
//               grants. Read data returns on a one-cycle valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,   // 1..8
  parameter int STARVE_MAX = 4    // 1..15
) (
  input  logic              clk,
  input  logic              rst,        // active-low, asynchronous
  // instruction-fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_kill,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  // data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  // memory side
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  // status
  output logic              busy
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [0:0] c_st_idle    = 1'b0;
  localparam logic [0:0] c_st_rd_wait = 1'b1;

  localparam logic [3:0] c_mem_lat    = 4'(MEM_LAT);
  localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [3:0]        r_lat_cnt;       // cycles left until mem_rdata is valid
  logic [3:0]        r_starve_cnt;    // data grants while a fetch waits
  logic              r_owner_d;       // 1 = outstanding read belongs to data
  logic              r_kill_pending;  // outstanding fetch was killed
  logic              r_if_rvalid;
  logic              r_d_rvalid;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic              w_gnt_if;
  logic              w_gnt_d;
  logic              w_rd_grant;
  logic              w_rd_wait;
  logic              w_capture;
  logic              w_fetch_killed;
  logic              w_mem_en;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;

  assign w_rd_wait      = (r_state == c_st_rd_wait);
  // The cycle in which the memory presents the read word.
  assign w_capture      = w_rd_wait && (r_lat_cnt == 4'd1);
  // A kill arriving in the capture cycle itself still suppresses the response.
  assign w_fetch_killed = r_kill_pending || if_kill;
  // Any grant except a data write occupies the memory for MEM_LAT cycles.
  assign w_rd_grant     = w_gnt_if || (w_gnt_d && !d_we);

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic: reads park in RD_WAIT, writes never leave IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_rd_grant) begin
          w_state_nxt = c_st_rd_wait;
        end
      end
      c_st_rd_wait: begin
        if (w_capture) begin
          w_state_nxt = c_st_idle;
        end
      end
      default: begin
        w_state_nxt = c_st_idle;
      end
    endcase
  end

  // FSM output logic: arbitration and memory command, only in IDLE and
  // forced low while reset is asserted
  always_comb begin
    w_gnt_if    = 1'b0;
    w_gnt_d     = 1'b0;
    w_mem_en    = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    if (rst && (r_state == c_st_idle)) begin
      if (d_req && ((r_starve_cnt < c_starve_max) || !if_req)) begin
        w_gnt_d     = 1'b1;
        w_mem_en    = 1'b1;
        w_mem_we    = d_we;
        w_mem_addr  = d_addr;
        w_mem_wdata = d_wdata;
      end else if (if_req) begin
        w_gnt_if    = 1'b1;
        w_mem_en    = 1'b1;
        w_mem_we    = 1'b0;
        w_mem_addr  = if_addr;
        w_mem_wdata = '0;
      end
    end
  end

  // Latency counter: loaded on a read grant, counts down while waiting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lat_cnt <= 4'd0;
    end else if (w_rd_grant) begin
      r_lat_cnt <= c_mem_lat;
    end else if (w_rd_wait && (r_lat_cnt != 4'd0)) begin
      r_lat_cnt <= r_lat_cnt - 4'd1;
    end
  end

  // Owner latch and fetch-kill tracking for the outstanding read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner_d      <= 1'b0;
      r_kill_pending <= 1'b0;
    end else if (w_rd_grant) begin
      r_owner_d      <= w_gnt_d;
      r_kill_pending <= w_gnt_if && if_kill;
    end else if (w_capture) begin
      r_kill_pending <= 1'b0;
    end else if (w_rd_wait && !r_owner_d && if_kill) begin
      r_kill_pending <= 1'b1;
    end
  end

  // Starvation counter: counts data grants that overtake a waiting fetch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve_cnt <= 4'd0;
    end else if (!if_req || w_gnt_if) begin
      r_starve_cnt <= 4'd0;
    end else if (w_gnt_d && (r_starve_cnt < c_starve_max)) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  // Fetch response: capture the word and pulse valid unless killed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= '0;
    end else begin
      r_if_rvalid <= 1'b0;
      if (w_capture && !r_owner_d && !w_fetch_killed) begin
        r_if_rvalid <= 1'b1;
        r_if_rdata  <= mem_rdata;
      end
    end
  end

  // Data response: capture the load word and pulse valid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_d_rvalid <= 1'b0;
      r_d_rdata  <= '0;
    end else begin
      r_d_rvalid <= 1'b0;
      if (w_capture && r_owner_d) begin
        r_d_rvalid <= 1'b1;
        r_d_rdata  <= mem_rdata;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output assignments
  // --------------------------------------------------------------------------
  assign if_gnt    = w_gnt_if;
  assign d_gnt     = w_gnt_d;
  assign mem_en    = w_mem_en;
  assign mem_we    = w_mem_we;
  assign mem_addr  = w_mem_addr;
  assign mem_wdata = w_mem_wdata;
  assign if_rvalid = r_if_rvalid;
  assign if_rdata  = r_if_rdata;
  assign d_rvalid  = r_d_rvalid;
  assign d_rdata   = r_d_rdata;
  assign busy      = w_rd_wait;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter with a
//               small fixed-latency memory model (MEM_LAT=2, STARVE_MAX=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_kill;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  int n_cmp;
  int n_err;

  mem_port_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .MEM_LAT   (MEM_LAT),
    .STARVE_MAX(STARVE_MAX)
  ) u_dut (
    .clk      (clk),
    .rst      (rst_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_kill  (if_kill),
    .if_gnt   (if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: preset contents plus a write overlay, MEM_LAT read pipe.
  // Cycles without a read command push a poison word through the pipe.
  logic [31:0] wr_mem   [0:63];
  logic        wr_valid [0:63];
  logic [31:0] pipe     [MEM_LAT];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    case (a)
      32'h4:   return 32'h0030_0113;
      32'h8:   return 32'h1111_1111;
      32'hC:   return 32'hCCCC_0003;
      default: return {16'hA5A5, a[15:0]};
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) wr_valid[i] <= 1'b0;
    end else if (mem_en && mem_we) begin
      wr_mem[mem_addr[7:2]]   <= mem_wdata;
      wr_valid[mem_addr[7:2]] <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (mem_en && !mem_we)
      pipe[0] <= wr_valid[mem_addr[7:2]] ? wr_mem[mem_addr[7:2]] : init_word(mem_addr);
    else
      pipe[0] <= 32'hDEAD_BEEF;
    for (int k = 1; k < MEM_LAT; k++) pipe[k] <= pipe[k-1];
  end

  assign mem_rdata = pipe[MEM_LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // {if_gnt, d_gnt} per cycle with both requesters held high (writes on data)
  logic [1:0] exp_seq [12];

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b00,
                2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};

    // ---------------- reset state, requests present but gated ----------------
    rst_n   = 1'b0;
    if_req  = 1'b1; if_addr = 32'h4; if_kill = 1'b0;
    d_req   = 1'b1; d_we = 1'b0; d_addr = 32'hC; d_wdata = 32'h0;
    next_cyc();
    mid();
    chk("rst_if_gnt",    32'(if_gnt),    32'h0);
    chk("rst_d_gnt",     32'(d_gnt),     32'h0);
    chk("rst_mem_en",    32'(mem_en),    32'h0);
    chk("rst_mem_addr",  mem_addr,       32'h0);
    chk("rst_busy",      32'(busy),      32'h0);
    chk("rst_if_rvalid", 32'(if_rvalid), 32'h0);
    chk("rst_if_rdata",  if_rdata,       32'h0);
    chk("rst_d_rdata",   d_rdata,        32'h0);
    next_cyc();
    if_req = 1'b0; d_req = 1'b0;
    rst_n  = 1'b1;
    next_cyc();

    // ---------------- single fetch --------------------------------------------
    if_req = 1'b1; if_addr = 32'h4;
    mid();
    chk("sf_if_gnt_T",  32'(if_gnt),  32'h1);
    chk("sf_d_gnt_T",   32'(d_gnt),   32'h0);
    chk("sf_mem_en_T",  32'(mem_en),  32'h1);
    chk("sf_mem_we_T",  32'(mem_we),  32'h0);
    chk("sf_mem_addr",  mem_addr,     32'h4);
    next_cyc();
    if_req = 1'b0;
    mid();
    chk("sf_busy_T1",   32'(busy),    32'h1);
    chk("sf_mem_en_T1", 32'(mem_en),  32'h0);
    next_cyc();
    mid();
    chk("sf_busy_T2",   32'(busy),      32'h1);
    chk("sf_rvalid_T2", 32'(if_rvalid), 32'h0);
    next_cyc();
    mid();
    chk("sf_rvalid_T3", 32'(if_rvalid), 32'h1);
    chk("sf_rdata_T3",  if_rdata,       32'h0030_0113);
    chk("sf_busy_T3",   32'(busy),      32'h0);
    next_cyc();
    mid();
    chk("sf_rvalid_T4", 32'(if_rvalid), 32'h0);
    next_cyc();

    // ---------------- simultaneous requests -----------------------------------
    if_req = 1'b1; if_addr = 32'h8;
    d_req  = 1'b1; d_we = 1'b0; d_addr = 32'hC;
    mid();
    chk("sim_d_gnt_T",   32'(d_gnt),  32'h1);
    chk("sim_if_gnt_T",  32'(if_gnt), 32'h0);
    chk("sim_addr_T",    mem_addr,    32'hC);
    next_cyc();
    d_req = 1'b0;
    mid();
    chk("sim_if_gnt_T1", 32'(if_gnt), 32'h0);
    chk("sim_busy_T1",   32'(busy),   32'h1);
    next_cyc();
    mid();
    chk("sim_if_gnt_T2", 32'(if_gnt), 32'h0);
    next_cyc();
    mid();
    chk("sim_if_gnt_T3",   32'(if_gnt),   32'h1);
    chk("sim_addr_T3",     mem_addr,      32'h8);
    chk("sim_d_rvalid_T3", 32'(d_rvalid), 32'h1);
    chk("sim_d_rdata_T3",  d_rdata,       32'hCCCC_0003);
    next_cyc();
    if_req = 1'b0;
    mid();
    chk("sim_d_rvalid_T4", 32'(d_rvalid), 32'h0);
    next_cyc();
    next_cyc();
    mid();
    chk("sim_if_rvalid_T6", 32'(if_rvalid), 32'h1);
    chk("sim_if_rdata_T6",  if_rdata,       32'h1111_1111);
    next_cyc();

    // ---------------- data write then fetch of the written word ---------------
    d_req  = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'h8;
    if_req = 1'b1; if_addr = 32'h10;
    mid();
    chk("wr_d_gnt_T",   32'(d_gnt),  32'h1);
    chk("wr_if_gnt_T",  32'(if_gnt), 32'h0);
    chk("wr_mem_en_T",  32'(mem_en), 32'h1);
    chk("wr_mem_we_T",  32'(mem_we), 32'h1);
    chk("wr_addr_T",    mem_addr,    32'h10);
    chk("wr_wdata_T",   mem_wdata,   32'h8);
    next_cyc();
    d_req = 1'b0; d_we = 1'b0;
    mid();
    chk("wr_if_gnt_T1",   32'(if_gnt),   32'h1);
    chk("wr_mem_we_T1",   32'(mem_we),   32'h0);
    chk("wr_wdata_T1",    mem_wdata,     32'h0);
    chk("wr_d_rvalid_T1", 32'(d_rvalid), 32'h0);
    next_cyc();
    if_req = 1'b0;
    mid();
    chk("wr_d_rvalid_T2", 32'(d_rvalid), 32'h0);
    next_cyc();
    next_cyc();
    mid();
    chk("wr_if_rvalid_T4", 32'(if_rvalid), 32'h1);
    chk("wr_if_rdata_T4",  if_rdata,       32'h8);
    next_cyc();

    // ---------------- starvation bound ----------------------------------------
    for (int i = 0; i < 12; i++) begin
      d_req  = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'(i);
      if_req = 1'b1; if_addr = 32'h4;
      mid();
      chk($sformatf("starve_c%0d", i), 32'({if_gnt, d_gnt}), 32'(exp_seq[i]));
      next_cyc();
    end
    d_req = 1'b0; d_we = 1'b0; if_req = 1'b0;
    next_cyc();
    next_cyc();
    next_cyc();

    // ---------------- fetch kill ----------------------------------------------
    if_req = 1'b1; if_addr = 32'h8;
    mid();
    chk("kill_if_gnt_T", 32'(if_gnt), 32'h1);
    next_cyc();
    if_req = 1'b0; if_kill = 1'b1;
    d_req  = 1'b1; d_we = 1'b0; d_addr = 32'h14;
    mid();
    chk("kill_d_gnt_T1", 32'(d_gnt), 32'h0);
    next_cyc();
    if_kill = 1'b0;
    mid();
    chk("kill_d_gnt_T2", 32'(d_gnt), 32'h0);
    next_cyc();
    mid();
    chk("kill_if_rvalid_T3", 32'(if_rvalid), 32'h0);
    chk("kill_if_rdata_T3",  if_rdata,       32'h0030_0113);
    chk("kill_d_gnt_T3",     32'(d_gnt),     32'h1);
    next_cyc();
    d_req = 1'b0; if_kill = 1'b1;   // kill must not touch a data read
    mid();
    chk("kill_if_rvalid_T4", 32'(if_rvalid), 32'h0);
    next_cyc();
    if_kill = 1'b0;
    next_cyc();
    mid();
    chk("kill_d_rvalid_T6", 32'(d_rvalid), 32'h1);
    chk("kill_d_rdata_T6",  d_rdata,       32'hA5A5_0014);
    chk("kill_if_rdata_T6", if_rdata,      32'h0030_0113);
    next_cyc();

    // ---------------- reset mid-read ------------------------------------------
    if_req = 1'b1; if_addr = 32'h8;
    mid();
    chk("rmr_if_gnt_T", 32'(if_gnt), 32'h1);
    next_cyc();
    if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'hC;
    rst_n  = 1'b0;
    #1;
    chk("rmr_busy",     32'(busy),   32'h0);
    chk("rmr_d_gnt",    32'(d_gnt),  32'h0);
    chk("rmr_mem_en",   32'(mem_en), 32'h0);
    chk("rmr_if_rdata", if_rdata,    32'h0);
    chk("rmr_d_rdata",  d_rdata,     32'h0);
    next_cyc();
    next_cyc();
    d_req = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk($sformatf("rmr_if_rvalid_%0d", i), 32'(if_rvalid), 32'h0);
      chk($sformatf("rmr_busy_%0d", i),      32'(busy),      32'h0);
      next_cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
